// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Sequential 32-bit execute stage. It takes an operand/op bundle from decode
//   and returns a registered result and flags to writeback. Valid/ready
//   handshakes are used on both sides. SUB is computed as a + ~b + 1. Each
//   shift moves one bit per cycle.
//
//   Ports
//     clk, reset_n          rising-edge clock, synchronous active-low reset
//     in_valid / in_ready   upstream handshake (in_ready is registered)
//     in_op, in_a, in_b     000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 NOT(a)
//                           110 SLL 111 SRL (shift amount = in_b[4:0])
//     out_valid / out_ready downstream handshake
//     out_result            result word
//     out_zero              result == 0
//     out_carry             ADD carry-out, SUB no-borrow, else 0
//     out_ovf               signed overflow for ADD/SUB, else 0
//     out_err               illegal op (shift requested with shifts compiled out)
//
//   Build option
//     ALU_SHIFT_EN  defined  : SLL/SRL iterate in S_SHIFT and out_err is tied 0.
//                   undefined: SLL/SRL finish in one cycle with result 0,
//                              zero=1 and err=1.
//
//   state   | meaning
//   S_IDLE  | in_ready high, waiting for a bundle
//   S_SHIFT | shifting the working value one bit per cycle (ALU_SHIFT_EN only)
//   S_HOLD  | result valid, held until out_ready
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

`ifdef ALU_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_is_sub;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_alu_res;

    assign w_accept   = in_valid & r_in_ready;
    assign w_is_shift = (in_op == OP_SLL) | (in_op == OP_SRL);
    assign w_is_sub   = (in_op == OP_SUB);
    assign w_is_arith = (in_op == OP_ADD) | w_is_sub;

    // The SUB path reuses the adder: the inverted B plus a carry-in of 1.
    assign w_opb = w_is_sub ? ~in_b : in_b;
    assign w_sum = {1'b0, in_a} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_ovf = (in_a[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        case (in_op)
            OP_ADD, OP_SUB: w_alu_res = w_sum[WIDTH-1:0];
            OP_AND:         w_alu_res = in_a & in_b;
            OP_OR:          w_alu_res = in_a | in_b;
            OP_XOR:         w_alu_res = in_a ^ in_b;
            OP_NOT:         w_alu_res = ~in_a;
            default:        w_alu_res = '0;
        endcase
    end

`ifdef ALU_SHIFT_EN
    logic [4:0]       r_cnt;
    logic             r_srl;
    logic             w_long_shift;
    logic [WIDTH-1:0] w_shift_nxt;

    assign w_long_shift = w_is_shift & (in_b[4:0] != 5'd0);
    assign w_shift_nxt  = r_srl ? (r_result >> 1) : (r_result << 1);
    assign out_err      = 1'b0;
`else
    logic r_err;
    assign out_err = r_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HOLD;
`ifdef ALU_SHIFT_EN
                    if (w_long_shift) w_state_nxt = S_SHIFT;
`endif
                end
            end
`ifdef ALU_SHIFT_EN
            S_SHIFT: if (r_cnt == 5'd1) w_state_nxt = S_HOLD;
`endif
            S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef ALU_SHIFT_EN
            r_cnt       <= 5'd0;
            r_srl       <= 1'b0;
`else
            r_err       <= 1'b0;
`endif
        end else begin
            // Registered ready keeps it low for the whole reset and
            // raises it on the first edge after release.
            r_in_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                        if (w_is_shift) begin
`ifdef ALU_SHIFT_EN
                            // r_result doubles as the shift working register.
                            r_result    <= in_a;
                            r_srl       <= in_op[0];
                            r_cnt       <= in_b[4:0];
                            r_zero      <= (in_a == '0);
                            r_out_valid <= (in_b[4:0] == 5'd0);
`else
                            r_result    <= '0;
                            r_zero      <= 1'b1;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
`endif
                        end else begin
                            r_result    <= w_alu_res;
                            r_zero      <= (w_alu_res == '0);
                            r_carry     <= w_is_arith & w_sum[WIDTH];
                            r_ovf       <= w_is_arith & w_ovf;
                            r_out_valid <= 1'b1;
`ifndef ALU_SHIFT_EN
                            r_err       <= 1'b0;
`endif
                        end
                    end
                end
`ifdef ALU_SHIFT_EN
                S_SHIFT: begin
                    r_result <= w_shift_nxt;
                    r_cnt    <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_zero      <= (w_shift_nxt == '0);
                        r_out_valid <= 1'b1;
                    end
                end
`endif
                S_HOLD: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;
    assign out_carry  = r_carry;
    assign out_ovf    = r_ovf;
endmodule
